// File: rtl/sonar_pkg.sv
// ---------------------------------------------------------------------------
// sonar_pkg
// Shared types and default constants for the ultrasonic sonar sequencer:
// FSM state encoding, default timing constants, the "no echo" distance code
// and the measurement result payload.
// ---------------------------------------------------------------------------
package sonar_pkg;

    // Default timing in clk cycles (50 MHz reference clock).
    localparam int unsigned TRIG_CYCLES_DEF    = 500;
    localparam int unsigned CYC_PER_MM_DEF     = 292;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1_500_000;
    localparam int unsigned HOLDOFF_CYCLES_DEF = 3_000_000;

    localparam int unsigned DIST_W = 32;
    localparam int unsigned CNT_W  = 32;

    // Distance reported when no usable echo was seen.
    localparam logic [DIST_W-1:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PULSE     = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_ECHO      = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // Result of one measurement, updated together on each valid pulse.
    typedef struct packed {
        logic              timeout;
        logic [DIST_W-1:0] distance;
    } meas_t;

    // Result reported for a missing or over-long echo.
    function automatic meas_t timeout_result();
        meas_t m;
        m.timeout  = 1'b1;
        m.distance = TIMEOUT_CODE;
        return m;
    endfunction

endpackage

// File: rtl/sonar_sequencer_if.sv
// ---------------------------------------------------------------------------
// sonar_sequencer_if
// Bundles the controller request/result handshake and the sensor pins.
//   trigger    : controller -> sequencer, level request held until triggerSuc
//   echo       : sensor     -> sequencer, asynchronous echo pin
//   trig_out   : sequencer  -> sensor, trigger pin
//   triggerSuc : sequencer  -> controller, 1-cycle "trigger pulse done"
//   valid      : sequencer  -> controller, 1-cycle "result updated"
//   distance   : sequencer  -> controller, last distance in mm
//   timeout    : sequencer  -> controller, last measurement timed out
// master = controller/sensor side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface sonar_sequencer_if;

    logic                           trigger;
    logic                           echo;
    logic                           trig_out;
    logic                           triggerSuc;
    logic                           valid;
    logic [sonar_pkg::DIST_W-1:0]   distance;
    logic                           timeout;

    modport master (
        output trigger,
        output echo,
        input  trig_out,
        input  triggerSuc,
        input  valid,
        input  distance,
        input  timeout
    );

    modport slave (
        input  trigger,
        input  echo,
        output trig_out,
        output triggerSuc,
        output valid,
        output distance,
        output timeout
    );

endinterface

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous input followed by a rise/fall
// detector working on the synchronized level.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   i_async   : asynchronous input
//   o_level   : synchronized level (registered)
//   o_rise_c  : synchronized level rose this cycle (decoded from flops)
//   o_fall_c  : synchronized level fell this cycle (decoded from flops)
// ---------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level  = r_sync;
    assign o_rise_c = r_sync & ~r_prev;
    assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/sonar_sequencer.sv
// ---------------------------------------------------------------------------
// sonar_sequencer
// Drives an ultrasonic range sensor: on a controller request it produces the
// trigger pulse, times the echo in whole millimetres, reports the result and
// then enforces a quiet hold-off before the next measurement.
//   clk    : clock, all logic on the rising edge
//   rst_n  : synchronous active-low reset
//   sonar  : sonar_sequencer_if.slave (trigger/echo in; trig_out,
//            triggerSuc, valid, distance, timeout out, all registered)
// ---------------------------------------------------------------------------
module sonar_sequencer
    import sonar_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
    parameter int unsigned CYC_PER_MM     = CYC_PER_MM_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sonar_sequencer_if.slave  sonar
);

    localparam int unsigned SUB_W = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC_PER_MM - 1);

    // The rise-detect cycle is already one echo-high cycle, so the counters
    // start as if that cycle had been counted.
    localparam logic [SUB_W-1:0]  SUB_INIT = (CYC_PER_MM > 1) ? SUB_W'(1) : SUB_W'(0);
    localparam logic [DIST_W-1:0] MM_INIT  = (CYC_PER_MM > 1) ? DIST_W'(0) : DIST_W'(1);

    localparam logic [CNT_W-1:0] LOAD_TRIG    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLDOFF = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SUB_W-1:0]  r_sub;
    logic [DIST_W-1:0] r_mm;
    logic              r_trig_out;
    logic              r_trig_suc;
    logic              r_valid;
    meas_t             r_meas;

    logic w_echo_level;
    logic w_echo_rise;
    logic w_echo_fall;
    logic w_cnt_zero;

    sync_edge u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (sonar.echo),
        .o_level  (w_echo_level),
        .o_rise_c (w_echo_rise),
        .o_fall_c (w_echo_fall)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // Measurement FSM; r_cnt is the single phase timer, reloaded on each entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sub      <= '0;
            r_mm       <= '0;
            r_trig_out <= 1'b0;
            r_trig_suc <= 1'b0;
            r_valid    <= 1'b0;
            r_meas     <= '0;
        end else begin
            r_trig_suc <= 1'b0;
            r_valid    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (sonar.trigger) begin
                        r_state    <= ST_PULSE;
                        r_trig_out <= 1'b1;
                        r_cnt      <= LOAD_TRIG;
                    end
                end

                // Once started the pulse runs to completion regardless of trigger.
                ST_PULSE: begin
                    if (w_cnt_zero) begin
                        r_state    <= ST_WAIT_RISE;
                        r_trig_out <= 1'b0;
                        r_trig_suc <= 1'b1;
                        r_cnt      <= LOAD_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_WAIT_RISE: begin
                    if (w_echo_rise) begin
                        r_state <= ST_ECHO;
                        r_sub   <= SUB_INIT;
                        r_mm    <= MM_INIT;
                        r_cnt   <= LOAD_TIMEOUT;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_HOLDOFF;
                        r_valid <= 1'b1;
                        r_meas  <= timeout_result();
                        r_cnt   <= LOAD_HOLDOFF;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                // Sub-counter divides echo time into mm steps; fall wins over timeout.
                ST_ECHO: begin
                    if (w_echo_fall) begin
                        r_state         <= ST_HOLDOFF;
                        r_valid         <= 1'b1;
                        r_meas.timeout  <= 1'b0;
                        r_meas.distance <= r_mm;
                        r_cnt           <= LOAD_HOLDOFF;
                    end else if (w_cnt_zero && w_echo_level) begin
                        r_state <= ST_HOLDOFF;
                        r_valid <= 1'b1;
                        r_meas  <= timeout_result();
                        r_cnt   <= LOAD_HOLDOFF;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_sub == SUB_LAST) begin
                            r_sub <= '0;
                            r_mm  <= r_mm + DIST_W'(1);
                        end else begin
                            r_sub <= r_sub + SUB_W'(1);
                        end
                    end
                end

                ST_HOLDOFF: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sonar.trig_out   = r_trig_out;
    assign sonar.triggerSuc = r_trig_suc;
    assign sonar.valid      = r_valid;
    assign sonar.distance   = r_meas.distance;
    assign sonar.timeout    = r_meas.timeout;

endmodule

// File: tb/tb_sonar_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sonar_sequencer
// Directed bench for sonar_sequencer with scaled timing: TRIG 500 cycles,
// 10 cycles/mm, 12000-cycle timeout, 2000-cycle hold-off.
// ---------------------------------------------------------------------------
module tb_sonar_sequencer;

    localparam int unsigned TRIG = 500;
    localparam int unsigned CPM  = 10;
    localparam int unsigned TO   = 12000;
    localparam int unsigned HO   = 2000;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    int n_pass = 0;
    int n_chk  = 0;

    int n_suc  = 0;
    int n_val  = 0;
    int viol   = 0;
    bit p_suc  = 1'b0;
    bit p_val  = 1'b0;

    sonar_sequencer_if u_if ();

    sonar_sequencer #(
        .TRIG_CYCLES    (TRIG),
        .CYC_PER_MM     (CPM),
        .TIMEOUT_CYCLES (TO),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sonar (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts strobes, flags overlap or multi-cycle strobes.
    always @(negedge clk) begin
        if (u_if.triggerSuc) begin
            n_suc = n_suc + 1;
            if (p_suc) viol = viol + 1;
        end
        if (u_if.valid) begin
            n_val = n_val + 1;
            if (p_val) viol = viol + 1;
        end
        if (u_if.triggerSuc && u_if.valid) viol = viol + 1;
        p_suc = u_if.triggerSuc;
        p_val = u_if.valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return u_if.trig_out;
            1:       return u_if.triggerSuc;
            default: return u_if.valid;
        endcase
    endfunction

    // Bounded wait: checks the current sample first, then ticks.
    task automatic wait_for(input int sel, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (sig(sel)) begin
                found = 1'b1;
                break;
            end
            if (i < budget) tick();
        end
    endtask

    // Observes one full trigger pulse and the triggerSuc strobe after it.
    task automatic run_pulse(input string tag, input int budget, input bit drop,
                             output int rise_cyc, output int suc_cyc);
        bit found;
        int len;
        wait_for(0, budget, found);
        chk({tag, " trig_out rise"}, 32'(found), 32'd1);
        rise_cyc = cyc;
        len = 0;
        while (u_if.trig_out && len < 1000) begin
            len++;
            tick();
        end
        chk({tag, " trig_out width"}, 32'(len), 32'(TRIG));
        chk({tag, " triggerSuc after fall"}, 32'(u_if.triggerSuc), 32'd1);
        suc_cyc = cyc;
        if (drop) u_if.trigger = 1'b0;
        tick();
        chk({tag, " triggerSuc single"}, 32'(u_if.triggerSuc), 32'd0);
    endtask

    // Holds echo high for n cycles, then checks the reported result.
    task automatic echo_meas(input string tag, input int n, input logic [31:0] exp_dist);
        bit found;
        u_if.echo = 1'b1;
        repeat (n) tick();
        u_if.echo = 1'b0;
        wait_for(2, 20, found);
        chk({tag, " valid seen"}, 32'(found), 32'd1);
        chk({tag, " distance"}, u_if.distance, exp_dist);
        chk({tag, " timeout"}, 32'(u_if.timeout), 32'd0);
        tick();
        chk({tag, " valid single"}, 32'(u_if.valid), 32'd0);
        chk({tag, " distance held"}, u_if.distance, exp_dist);
    endtask

    initial begin
        int  r1, r2, r3, s, t0, v_before;
        bit  found;

        rst_n       = 1'b0;
        u_if.trigger = 1'b0;
        u_if.echo    = 1'b0;
        repeat (3) tick();
        chk("rst trig_out",   32'(u_if.trig_out),   32'd0);
        chk("rst triggerSuc", 32'(u_if.triggerSuc), 32'd0);
        chk("rst valid",      32'(u_if.valid),      32'd0);
        chk("rst distance",   u_if.distance,        32'd0);
        chk("rst timeout",    32'(u_if.timeout),    32'd0);
        rst_n = 1'b1;
        tick();

        // A: 1000 mm echo, then an echo glitch during hold-off.
        u_if.trigger = 1'b1;
        run_pulse("A", 5, 1'b1, r1, s);
        echo_meas("A", 1000 * CPM, 32'd1000);
        repeat (100) tick();
        u_if.echo = 1'b1;
        repeat (3) tick();
        u_if.echo = 1'b0;
        repeat (2000) tick();

        // B: one-cycle trigger request in IDLE, sub-mm echo.
        u_if.trigger = 1'b1;
        tick();
        u_if.trigger = 1'b0;
        run_pulse("B", 5, 1'b0, r1, s);
        chk("B glitch no valid", 32'(n_val), 32'd1);
        echo_meas("B", CPM - 1, 32'd0);
        repeat (HO + 10) tick();

        // C: no echo -> timeout; trigger held continuously from here.
        u_if.trigger = 1'b1;
        run_pulse("C", 5, 1'b0, r1, s);
        wait_for(2, TO + 10, found);
        chk("C valid seen",      32'(found),        32'd1);
        chk("C timeout latency", 32'(cyc - s),      32'(TO));
        chk("C distance",        u_if.distance,     32'hFFFF_FFFF);
        chk("C timeout",         32'(u_if.timeout), 32'd1);

        // D: next pulse under held trigger, echo of 19 cycles -> 1 mm.
        run_pulse("D", HO + 20, 1'b0, r2, s);
        chk("D period exact", 32'(r2 - r1), 32'(TRIG + TO + HO + 1));
        chk("D period min",   32'(r2 - r1 >= int'(TRIG + HO)), 32'd1);
        echo_meas("D", 2 * CPM - 1, 32'd1);

        // E: reset while in ECHO.
        run_pulse("E", HO + 20, 1'b0, r3, s);
        chk("E period min", 32'(r3 - r2 >= int'(TRIG + 2 * CPM - 1 + HO)), 32'd1);
        u_if.echo = 1'b1;
        repeat (50) tick();
        v_before = n_val;
        rst_n = 1'b0;
        u_if.trigger = 1'b0;
        tick();
        chk("E rst trig_out", 32'(u_if.trig_out), 32'd0);
        chk("E rst distance", u_if.distance,      32'd0);
        chk("E rst valid",    32'(u_if.valid),    32'd0);
        u_if.echo = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("E no valid after abort", 32'(n_val), 32'(v_before));

        // F: normal measurement after reset, 25 cycles -> 2 mm.
        u_if.trigger = 1'b1;
        run_pulse("F", 5, 1'b1, r1, s);
        echo_meas("F", 25, 32'd2);
        repeat (HO + 10) tick();

        // G: echo that stays high past the timeout.
        u_if.trigger = 1'b1;
        run_pulse("G", 5, 1'b1, r1, s);
        u_if.echo = 1'b1;
        t0 = cyc;
        wait_for(2, TO + 20, found);
        chk("G valid seen",      32'(found),        32'd1);
        chk("G echo latency",    32'(cyc - t0),     32'(TO + 3));
        chk("G distance",        u_if.distance,     32'hFFFF_FFFF);
        chk("G timeout",         32'(u_if.timeout), 32'd1);
        u_if.echo = 1'b0;
        repeat (50) tick();

        chk("strobe overlap/width", 32'(viol),  32'd0);
        chk("triggerSuc count",     32'(n_suc), 32'd7);
        chk("valid count",          32'(n_val), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sonar_sequencer.md
SONAR_SEQUENCER -- requirements
Module: sonar_sequencer

Interface
REQ-001 Parameter TRIG_CYCLES, default 500: trig_out high time in clk cycles (10 us at 50 MHz).
REQ-002 Parameter CYC_PER_MM, default 292: echo-high clk cycles per 1 mm of target distance (round trip).
REQ-003 Parameter TIMEOUT_CYCLES, default 1_500_000: max wait for echo rise, and max echo-high time.
REQ-004 Parameter HOLDOFF_CYCLES, default 3_000_000: minimum quiet time after each measurement before the next trig_out.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 trigger  input  1  level measurement request from the system controller, held until triggerSuc.
REQ-008 echo  input  1  sensor echo pin, asynchronous to clk.
REQ-009 trig_out  output  1  sensor trigger pin.
REQ-010 triggerSuc  output  1  one-cycle pulse: the trigger pulse completed.
REQ-011 valid  output  1  one-cycle pulse: distance and timeout are updated.
REQ-012 distance  output  32  last measured distance in mm.
REQ-013 timeout  output  1  last measurement had no echo rise or an over-long echo; updated with valid.

Function
REQ-014 echo shall pass through a 2-flop synchronizer; rise/fall shall be detected on the synchronized signal (2-cycle input latency).
REQ-015 FSM states: IDLE, PULSE, WAIT_RISE, ECHO, HOLDOFF.
REQ-016 IDLE: trigger sampled high -> PULSE next cycle; otherwise stay.
REQ-017 PULSE: trig_out shall be high for exactly TRIG_CYCLES cycles; the cycle after it falls, triggerSuc = 1 for one cycle and the state is WAIT_RISE.
REQ-018 WAIT_RISE: sync rise -> ECHO, and the mm counter and sub-counter clear.
REQ-019 WAIT_RISE timeout: no rise within TIMEOUT_CYCLES -> valid = 1, timeout = 1, distance = 32'hFFFF_FFFF, then HOLDOFF.
REQ-020 ECHO: a sub-counter shall count 0..CYC_PER_MM-1 and wrap; on each wrap the mm counter increments; no divider shall be used.
REQ-021 ECHO, on sync fall: valid = 1 for one cycle, distance = mm counter (partial mm truncated), timeout = 0, then HOLDOFF.
REQ-022 ECHO still high after TIMEOUT_CYCLES: same response as REQ-019.
REQ-023 HOLDOFF shall last HOLDOFF_CYCLES cycles and then go to IDLE; trigger is ignored during HOLDOFF and served once IDLE is reached.
REQ-024 distance and timeout shall hold their values between valid pulses.
REQ-025 triggerSuc and valid shall never be high in the same cycle and shall never be high for more than 1 cycle.
REQ-026 A trigger drop before triggerSuc shall not abort a started pulse.
REQ-027 Echo activity in IDLE, PULSE or HOLDOFF shall be ignored.
REQ-028 All outputs shall be registered.

Reset
REQ-029 With rst_n low at a clk edge: state = IDLE, trig_out = 0, triggerSuc = 0, valid = 0, distance = 0, timeout = 0, all counters and synchronizer flops = 0.
REQ-030 Reset mid-operation (any state) shall take effect on the next edge; no valid or triggerSuc shall be emitted for the aborted measurement.

Structure
REQ-031 The state encoding and the default constants (TRIG_CYCLES, CYC_PER_MM, TIMEOUT_CYCLES, HOLDOFF_CYCLES, timeout code 32'hFFFF_FFFF) shall live in shared package sonar_pkg.
REQ-032 The synchronizer plus rise/fall detector shall be one sub-module, sync_edge, outputting sync level, rise and fall.
REQ-033 A single shared down/up counter shall time PULSE, WAIT_RISE, ECHO and HOLDOFF, reloaded on each state entry.

Verification
REQ-034 Bench: trigger high at t0 -> trig_out high exactly 500 cycles, triggerSuc one cycle after fall, never asserted twice.
REQ-035 Bench: echo high 292_000 cycles -> valid pulse, distance = 1000, timeout = 0; echo 291 cycles -> distance = 0.
REQ-036 Bench: no echo after triggerSuc -> valid at 1_500_000 cycles, distance = 32'hFFFF_FFFF, timeout = 1.
REQ-037 Bench: trigger held high continuously -> consecutive trig_out rising edges no closer than 500 + echo + 3_000_000 cycles.
REQ-038 Bench: rst_n low during ECHO -> next cycle trig_out = 0, distance = 0, no valid pulse; after release, next trigger is served normally.
REQ-039 Bench: echo glitch during HOLDOFF plus trigger pulse of 1 cycle in IDLE -> glitch ignored, full 500-cycle trig_out produced.
